// File: rtl/lift_ctrl_n.sv
// lift_ctrl_n: collective-order (SCAN) freight lift controller with a timed,
// obstruction-aware door dwell and an emergency return to the ground floor.
module lift_ctrl_n #(
    parameter int FLOORS      = 5,
    parameter int DOOR_CYCLES = 50,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] call,
    input  logic [FLOORS-1:0] fc,
    input  logic              emergencia,
    input  logic              puerta,
    output logic [1:0]        motor,
    output logic [IDX_W-1:0]  floor_idx,
    output logic [FLOORS-1:0] pending,
    output logic              door_open,
    output logic              led_emergencia,
    output logic              led_puerta,
    output logic              busy
);
    localparam int TW = $clog2(DOOR_CYCLES);
    localparam logic [TW-1:0] T_LOAD = TW'(DOOR_CYCLES - 1);
    localparam logic [IDX_W-1:0] TOP = IDX_W'(FLOORS - 1);

    typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG_DOWN, EMERG_HOLD} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  floor_q, floor_d;
    logic [FLOORS-1:0] pend_q, pend_d;
    logic [FLOORS-1:0] cur_m, up_m, dn_m, above_m, below_m;
    logic              dir_q, dir_d, led_puerta_q;
    logic [TW-1:0]     timer_q, timer_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            pend_q       <= '0;
            dir_q        <= 1'b1;
            timer_q      <= '0;
            led_puerta_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            pend_q       <= pend_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            led_puerta_q <= puerta;
        end
    end

    always_comb begin
        cur_m   = FLOORS'(1) << floor_q;
        up_m    = cur_m << 1;
        dn_m    = cur_m >> 1;
        below_m = cur_m - FLOORS'(1);
        above_m = ~(below_m | cur_m);
        state_d = state_q;
        floor_d = floor_q;
        pend_d  = pend_q;
        dir_d   = dir_q;
        timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
        if (state_q == EMERG_HOLD) begin
            if (!emergencia) begin
                state_d = DOOR;
                timer_d = T_LOAD;
            end
        end else if (state_q == EMERG_DOWN) begin
            if (!puerta && (|(fc & dn_m))) floor_d = floor_q - IDX_W'(1);
            if (floor_d == '0 && fc[0]) state_d = EMERG_HOLD;
        end else if (emergencia) begin
            pend_d  = '0;
            state_d = (floor_q == '0 && fc[0]) ? EMERG_HOLD : EMERG_DOWN;
        end else begin
            pend_d = pend_q | call;
            case (state_q)
                IDLE: begin
                    // A request for the floor we stand on just opens the door
                    if (|(pend_d & cur_m)) begin
                        pend_d  = pend_d & ~cur_m;
                        state_d = DOOR;
                        timer_d = T_LOAD;
                    end else if (!puerta && (|(pend_q & above_m)) && (dir_q || !(|(pend_q & below_m)))) begin
                        state_d = MOVE_UP;
                        dir_d   = 1'b1;
                    end else if (!puerta && (|(pend_q & below_m))) begin
                        state_d = MOVE_DOWN;
                        dir_d   = 1'b0;
                    end
                end
                MOVE_UP: begin
                    if (!puerta && (|(fc & up_m))) begin
                        floor_d = floor_q + IDX_W'(1);
                        if ((|(pend_d & up_m)) || floor_d == TOP) begin
                            pend_d  = pend_d & ~up_m;
                            state_d = DOOR;
                            timer_d = T_LOAD;
                        end
                    end else if (floor_q == TOP) begin
                        state_d = DOOR;
                        timer_d = T_LOAD;
                    end
                end
                MOVE_DOWN: begin
                    if (!puerta && (|(fc & dn_m))) begin
                        floor_d = floor_q - IDX_W'(1);
                        if ((|(pend_d & dn_m)) || floor_d == '0) begin
                            pend_d  = pend_d & ~dn_m;
                            state_d = DOOR;
                            timer_d = T_LOAD;
                        end
                    end else if (floor_q == '0) begin
                        state_d = DOOR;
                        timer_d = T_LOAD;
                    end
                end
                default: begin
                    pend_d = pend_d & ~cur_m;
                    if (puerta || (|(call & cur_m))) timer_d = T_LOAD;
                    else if (timer_q == '0) state_d = IDLE;
                end
            endcase
        end
    end

    assign motor = puerta ? 2'b00 :
                   (state_q == MOVE_UP) ? 2'b01 :
                   (state_q == MOVE_DOWN || state_q == EMERG_DOWN) ? 2'b10 : 2'b00;
    assign floor_idx      = floor_q;
    assign pending        = pend_q;
    assign door_open      = (state_q == DOOR);
    assign led_emergencia = (state_q == EMERG_DOWN || state_q == EMERG_HOLD);
    assign led_puerta     = led_puerta_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_lift_ctrl_n.sv
// tb_lift_ctrl_n: directed-vector bench for lift_ctrl_n (5 floors, 50-cycle dwell).
module tb_lift_ctrl_n;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] call = '0;
    logic [4:0] fc = 5'b00001;
    logic       emergencia = 1'b0;
    logic       puerta = 1'b0;
    logic [1:0] motor;
    logic [3:0] floor_idx;
    logic [4:0] pending;
    logic       door_open, led_emergencia, led_puerta, busy;
    int         n_chk = 0;
    int         n_fail = 0;

    lift_ctrl_n #(.FLOORS(5), .DOOR_CYCLES(50), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .call(call), .fc(fc), .emergencia(emergencia),
        .puerta(puerta), .motor(motor), .floor_idx(floor_idx), .pending(pending),
        .door_open(door_open), .led_emergencia(led_emergencia), .led_puerta(led_puerta),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with the door open; optionally pokes puerta (pc == 0) or a call at cycle poke
    task automatic dwell(input string tag, input int exp, input int poke, input logic [4:0] pc);
        int n = 0;
        while (door_open && n < 400) begin
            if (n == poke) begin
                if (pc == '0) puerta = 1'b1;
                else call = pc;
            end else begin
                puerta = 1'b0;
                call   = '0;
            end
            n++;
            tick();
        end
        puerta = 1'b0;
        call   = '0;
        check(tag, n, exp);
    endtask

    initial begin
        #12;
        check("rst_motor", motor, 2'b00);
        check("rst_floor", floor_idx, 0);
        check("rst_pend", pending, 0);
        check("rst_door", door_open, 0);
        check("rst_leds", {led_emergencia, led_puerta, busy}, 3'b000);
        reset = 1'b1;
        tick();

        // Single call to the top floor
        call = 5'b10000;
        tick();
        call = '0;
        check("s1_latch", pending, 5'b10000);
        check("s1_motor_wait", motor, 2'b00);
        tick();
        check("s1_motor_up", motor, 2'b01);
        for (int k = 1; k < 5; k++) begin
            fc = 5'(1 << k);
            tick();
            check("s1_floor", floor_idx, k);
        end
        check("s1_stop_motor", motor, 2'b00);
        check("s1_door", door_open, 1);
        check("s1_pend_clr", pending, 0);
        dwell("s1_dwell", 50, -1, '0);
        check("s1_idle", {busy, pending}, 0);

        // SCAN: going down from 5 with calls at 3 (ahead) and 5 (behind)
        call = 5'b00001;
        tick();
        call = '0;
        tick();
        check("s2_down", motor, 2'b10);
        fc = 5'b01000;
        tick();
        check("s2_floor4", floor_idx, 3);
        call = 5'b10100;
        tick();
        check("s2_pend", pending, 5'b10101);
        call = 5'b00100;
        fc = 5'b00100;
        tick();
        call = '0;
        check("s2_stop3", {floor_idx, door_open, motor}, {4'd2, 1'b1, 2'b00});
        check("s2_served", pending, 5'b10001);
        dwell("s2_dwell3", 50, -1, '0);
        tick();
        check("s2_keep_down", motor, 2'b10);
        fc = 5'b00010;
        tick();
        fc = 5'b00001;
        tick();
        check("s2_stop1", {floor_idx, door_open}, {4'd0, 1'b1});
        check("s2_pend1", pending, 5'b10000);
        dwell("s2_dwell1", 50, -1, '0);
        tick();
        check("s2_reverse", motor, 2'b01);

        // Door obstruction while moving up
        fc = 5'b00010;
        tick();
        fc = 5'b00100;
        tick();
        puerta = 1'b1;
        #1;
        check("s3_motor_obst", motor, 2'b00);
        for (int k = 0; k < 10; k++) tick();
        check("s3_held", {floor_idx, busy, door_open}, {4'd2, 1'b1, 1'b0});
        check("s3_led", led_puerta, 1);
        puerta = 1'b0;
        #1;
        check("s3_resume", motor, 2'b01);
        fc = 5'b01000;
        tick();
        fc = 5'b10000;
        tick();
        check("s3_arrive", {floor_idx, door_open, pending}, {4'd4, 1'b1, 5'b0});
        dwell("s4_puerta_reload", 97, 46, '0);

        // Call for the current floor opens, then re-extends, the door
        call = 5'b10000;
        tick();
        call = '0;
        check("s4_call_here", {door_open, pending}, {1'b1, 5'b0});
        dwell("s4_call_reload", 61, 10, 5'b10000);
        check("s4_idle", {busy, pending}, 0);

        // Emergency during a descent
        call = 5'b00011;
        tick();
        call = '0;
        tick();
        fc = 5'b01000;
        tick();
        fc = '0;
        emergencia = 1'b1;
        call = 5'b00100;
        tick();
        call = '0;
        check("s5_pend_clr", pending, 0);
        check("s5_emerg", {led_emergencia, motor, floor_idx}, {1'b1, 2'b10, 4'd3});
        fc = 5'b00100;
        tick();
        fc = 5'b00010;
        tick();
        fc = 5'b00001;
        tick();
        check("s5_hold", {floor_idx, motor, led_emergencia, busy}, {4'd0, 2'b00, 1'b1, 1'b1});
        call = 5'b11111;
        tick();
        call = '0;
        check("s5_ignore", pending, 0);
        emergencia = 1'b0;
        tick();
        check("s5_door", {door_open, led_emergencia, floor_idx}, {1'b1, 1'b0, 4'd0});
        dwell("s5_dwell", 50, -1, '0);
        emergencia = 1'b1;
        tick();
        check("s5_hold_direct", {led_emergencia, motor, door_open}, {1'b1, 2'b00, 1'b0});
        emergencia = 1'b0;
        tick();
        dwell("s5_dwell2", 50, -1, '0);

        // Asynchronous reset during a descent
        call = 5'b01000;
        tick();
        call = '0;
        tick();
        fc = 5'b00010;
        tick();
        fc = 5'b00100;
        tick();
        call = 5'b00001;
        tick();
        call = '0;
        fc = 5'b01000;
        tick();
        check("s6_stop4", {floor_idx, pending}, {4'd3, 5'b00001});
        dwell("s6_dwell", 50, -1, '0);
        tick();
        check("s6_down", motor, 2'b10);
        #3;
        reset = 1'b0;
        #1;
        check("s6_async", {motor, floor_idx, busy, pending, door_open}, {2'b00, 4'd0, 1'b0, 5'b0, 1'b0});
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_ctrl_n.md
Name: lift_ctrl_n

Overview:
Parametrised freight-lift controller for N floors. It latches hall/cab calls into a pending mask and serves them in collective (SCAN) order, holding the previous travel direction while requests remain ahead. It runs a timed, obstruction-aware door dwell and an emergency return-to-ground sequence. It drives the 2-bit motor command and the floor index; the existing motor driver and 7-segment decoder sit downstream.

Parameters:
FLOORS, 5, number of floors (2..16); floor 1 = index 0 = bit 0
DOOR_CYCLES, 50, clock cycles the door dwell lasts with no obstruction (>=2)
IDX_W, 4, width of floor index (>= clog2(FLOORS))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
call  in  FLOORS  request buttons, level, bit k = floor k+1
fc  in  FLOORS  floor limit switches, bit k high while cab is level at floor k+1
emergencia  in  1  emergency input, active high
puerta  in  1  door open/obstructed sensor, active high
motor  out  2  00 stop, 01 up, 10 down (11 never driven)
floor_idx  out  IDX_W  last floor reached
pending  out  FLOORS  latched request mask
door_open  out  1  high during door dwell
led_emergencia  out  1  high while emergency sequence active
led_puerta  out  1  registered copy of puerta
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, active-low): state IDLE, floor_idx 0, pending 0, dir up, timer 0, door_open 0, led_emergencia 0, led_puerta 0. motor reads 00.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG_DOWN, EMERG_HOLD.
- Call latching (all states except EMERG_*): pending |= call on each edge.
  - In IDLE or DOOR, a call for floor_idx is not latched. Instead, DOOR is entered (from IDLE) or re-entered (timer reloads).
- IDLE:
  - If pending has bits above floor_idx and (dir = up or no bits below), go to MOVE_UP, dir = up.
  - Otherwise, if bits below, go to MOVE_DOWN, dir = down.
  - A call sampled at edge E sets pending at E; the state leaves IDLE at E+1.
- MOVE_UP / MOVE_DOWN:
  - floor_idx updates only when fc bit floor_idx+1 (up) or floor_idx-1 (down) is high. All other fc bits are ignored.
  - On an update to floor k with pending[k] = 1: clear pending[k], enter DOOR. Motor is 00 from that edge.
  - In MOVE_UP at floor FLOORS-1, or MOVE_DOWN at floor 0: forced transition to DOOR.
- DOOR:
  - On entry the timer loads DOOR_CYCLES-1 and decrements each cycle. Exit to IDLE when timer = 0 and puerta = 0, so the dwell lasts exactly DOOR_CYCLES cycles.
  - puerta = 1 reloads the timer.
- motor is combinational from state and the puerta input:
  - MOVE_UP gives 01. MOVE_DOWN and EMERG_DOWN give 10. Every other state gives 00.
  - puerta = 1 forces 00 in all states; the state is held, with zero-cycle latency.
- Emergency (emergencia = 1 sampled in any non-EMERG state):
  - pending clears and led_emergencia = 1.
  - If floor_idx = 0 and fc[0] = 1, go to EMERG_HOLD; else go to EMERG_DOWN.
  - In EMERG_DOWN, floor_idx tracks downward. Reaching fc[0] enters EMERG_HOLD.
- EMERG_HOLD: motor 00. When emergencia = 0, go to DOOR at floor 0 and led_emergencia clears.
- Calls are ignored in both EMERG states. emergencia takes priority over any simultaneous floor arrival or call on the same edge.
- Simultaneous call and arrival on the same edge for the arrival floor: the bit is treated as served and pending stays 0.
- Reset asserted mid-move forces motor 00 immediately (asynchronous).

Test Plan:
- Reset, fc = 00001, pulse call = 10000 → pending 10000 at next edge, motor 01 at the edge after. Step fc through 00010…10000: floor_idx counts 1..4, motor 00 and door_open 1 for exactly 50 cycles, then IDLE with pending 0.
- At floor 3 (idx 2) moving up toward 5, pulse call = 00010 and call = 00001 → stops at 5 first, then descends, stopping at 2 then 1, each with a full door dwell (SCAN order).
- During MOVE_UP hold puerta = 1 for 10 cycles → motor 00 combinationally, state held, led_puerta 1 one cycle later. Release → motor 01 resumes.
- In DOOR, pulse puerta at timer = 3 → timer reloads to 49, dwell extends. A call for the current floor also reloads the timer.
- At idx 3 moving up with pending 10011, assert emergencia → pending 0, led_emergencia 1, motor 10 down to fc 00001, EMERG_HOLD with motor 00. Calls ignored. Deassert → DOOR at floor 1, then IDLE.
- Assert reset during MOVE_DOWN → motor 00, state IDLE, floor_idx 0 with no clock edge.
